// File: rtl/zube_z80_front.sv
// Z80 pad front end: synchronises the raw strobes and buses, glitch-filters the
// strobes and emits single-cycle mailbox read/write events plus the data-bus direction.
module zube_z80_front #(
  parameter int          SYNC_STAGES   = 2,
  parameter int          FILTER_CYCLES = 2,
  parameter logic [7:0]  PORT_BASE     = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_write_strobe_b,
  input  logic       z80_read_strobe_b,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] z80_data_bus_in,
  output logic       wr_pulse_out,
  output logic       rd_pulse_out,
  output logic       port_sel_out,
  output logic [7:0] wr_data_out,
  output logic       z80_bus_dir,
  output logic       conflict_out
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_QUAL  = 3'd1,
    RD_QUAL  = 3'd2,
    WR_HOLD  = 3'd3,
    RD_HOLD  = 3'd4,
    CONFLICT = 3'd5
  } state_t;

  localparam logic [3:0] FILTER_N = 4'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] wr_chain;
  logic [SYNC_STAGES-1:0] rd_chain;
  logic [7:0]             addr_chain [SYNC_STAGES];
  logic [7:0]             data_chain [SYNC_STAGES];

  logic       sync_wr;
  logic       sync_rd;
  logic [7:0] sync_addr;
  logic [7:0] sync_data;
  logic       port_match;

  state_t     state;
  logic [3:0] cnt;

  // Strobes idle high, so their synchronisers reset to 1 to avoid a phantom cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_chain <= '1;
      rd_chain <= '1;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        addr_chain[i] <= '0;
        data_chain[i] <= '0;
      end
    end else begin
      wr_chain      <= {wr_chain[SYNC_STAGES-2:0], z80_write_strobe_b};
      rd_chain      <= {rd_chain[SYNC_STAGES-2:0], z80_read_strobe_b};
      addr_chain[0] <= z80_address_bus;
      data_chain[0] <= z80_data_bus_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        addr_chain[i] <= addr_chain[i-1];
        data_chain[i] <= data_chain[i-1];
      end
    end
  end

  assign sync_wr    = wr_chain[SYNC_STAGES-1];
  assign sync_rd    = rd_chain[SYNC_STAGES-1];
  assign sync_addr  = addr_chain[SYNC_STAGES-1];
  assign sync_data  = data_chain[SYNC_STAGES-1];
  assign port_match = (sync_addr[7:1] == PORT_BASE[7:1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      wr_pulse_out <= 1'b0;
      rd_pulse_out <= 1'b0;
      port_sel_out <= 1'b0;
      wr_data_out  <= 8'h00;
      z80_bus_dir  <= 1'b0;
      conflict_out <= 1'b0;
    end else begin
      wr_pulse_out <= 1'b0;
      rd_pulse_out <= 1'b0;
      conflict_out <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync_wr && !sync_rd) begin
            state        <= CONFLICT;
            conflict_out <= 1'b1;
          end else if (!sync_wr) begin
            state <= WR_QUAL;
            cnt   <= 4'd1;
          end else if (!sync_rd) begin
            state <= RD_QUAL;
            cnt   <= 4'd1;
          end
        end
        // Once the strobe has been low for FILTER_CYCLES samples it is committed.
        WR_QUAL: begin
          if (cnt == FILTER_N) begin
            state <= WR_HOLD;
            if (port_match) begin
              wr_pulse_out <= 1'b1;
              port_sel_out <= sync_addr[0];
              wr_data_out  <= sync_data;
            end
          end else if (!sync_rd) begin
            state        <= CONFLICT;
            conflict_out <= 1'b1;
          end else if (sync_wr) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RD_QUAL: begin
          if (cnt == FILTER_N) begin
            state <= RD_HOLD;
            if (port_match) begin
              rd_pulse_out <= 1'b1;
              port_sel_out <= sync_addr[0];
              z80_bus_dir  <= 1'b1;
            end
          end else if (!sync_wr) begin
            state        <= CONFLICT;
            conflict_out <= 1'b1;
          end else if (sync_rd) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        WR_HOLD: begin
          if (sync_wr) state <= IDLE;
        end
        RD_HOLD: begin
          if (sync_rd) begin
            state       <= IDLE;
            z80_bus_dir <= 1'b0;
          end
        end
        CONFLICT: begin
          z80_bus_dir <= 1'b0;
          if (sync_wr && sync_rd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zube_z80_front.sv
// Randomised bench for zube_z80_front: a bus-cycle level model predicts events and
// bus-direction windows; a monitor pops and compares them as the DUT produces them.
module tb_zube_z80_front;

  localparam int SYNC   = 2;
  localparam int FILTER = 2;
  localparam int LAT    = SYNC + FILTER + 1;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_CF = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic        sel;
    logic [7:0]  wdata;
    logic [31:0] t;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       wr_b;
  logic       rd_b;
  logic [7:0] addr;
  logic [7:0] din;
  logic       wr_pulse_out;
  logic       rd_pulse_out;
  logic       port_sel_out;
  logic [7:0] wr_data_out;
  logic       z80_bus_dir;
  logic       conflict_out;

  ev_t        exp_q[$];
  logic [7:0] dir_q[$];
  logic [7:0] last_wr;
  int         cyc;
  int         dir_run;
  int         n_checks;
  int         n_fail;

  zube_z80_front #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILTER), .PORT_BASE(8'h80)) dut (
    .clk                (clk),
    .reset              (rst),
    .z80_write_strobe_b (wr_b),
    .z80_read_strobe_b  (rd_b),
    .z80_address_bus    (addr),
    .z80_data_bus_in    (din),
    .wr_pulse_out       (wr_pulse_out),
    .rd_pulse_out       (rd_pulse_out),
    .port_sel_out       (port_sel_out),
    .wr_data_out        (wr_data_out),
    .z80_bus_dir        (z80_bus_dir),
    .conflict_out       (conflict_out)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk_eq(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic chk_near(input string name, input int act, input int exp);
    n_checks++;
    if (act < exp - 1 || act > exp + 1) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    end
  endtask

  function automatic bit is_match(input logic [7:0] a);
    return (a >> 1) == (8'h80 >> 1);
  endfunction

  // driver: one Z80 bus cycle; op 0=write 1=read 2=both strobes; strobe low len clocks
  task automatic bus_cycle(input int op, input logic [7:0] a, input logic [7:0] d,
                           input int len, input int gap);
    int  c;
    ev_t e;
    @(negedge clk);
    c    = cyc;
    addr = a;
    din  = d;
    if (op == 0 || op == 2) wr_b = 1'b0;
    if (op == 1 || op == 2) rd_b = 1'b0;
    if (op == 2) begin
      e = '{kind: K_CF, sel: 1'b0, wdata: 8'h00, t: 32'(c + SYNC + 1)};
      exp_q.push_back(e);
    end else if (is_match(a) && len >= FILTER) begin
      if (op == 0) begin
        last_wr = d;
        e = '{kind: K_WR, sel: a[0], wdata: d, t: 32'(c + LAT)};
      end else begin
        e = '{kind: K_RD, sel: a[0], wdata: last_wr, t: 32'(c + LAT)};
        if (len >= FILTER + 2) dir_q.push_back(8'(len - FILTER));
      end
      exp_q.push_back(e);
    end
    repeat (len) @(negedge clk);
    wr_b = 1'b1;
    rd_b = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // monitor / scoreboard
  initial begin
    ev_t e;
    int  np;
    cyc     = 0;
    dir_run = 0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
        dir_run = 0;
      end else begin
        np = int'(wr_pulse_out) + int'(rd_pulse_out) + int'(conflict_out);
        if (np > 0) begin
          chk_eq("pulse_onehot", np, 1);
          if (exp_q.size() == 0) begin
            chk_eq("unexpected_event", np, 0);
          end else begin
            e = exp_q.pop_front();
            chk_eq("event_kind", wr_pulse_out ? 0 : (rd_pulse_out ? 1 : 2), int'(e.kind));
            chk_near("event_latency", cyc, int'(e.t));
            if (e.kind != K_CF) begin
              chk_eq("port_sel", int'(port_sel_out), int'(e.sel));
              chk_eq("wr_data", int'(wr_data_out), int'(e.wdata));
            end
          end
        end
        if (z80_bus_dir) begin
          dir_run++;
        end else if (dir_run > 0) begin
          if (dir_q.size() == 0) chk_eq("unexpected_bus_dir", dir_run, 0);
          else chk_eq("bus_dir_len", dir_run, int'(dir_q.pop_front()));
          dir_run = 0;
        end
      end
    end
  end

  // stimulus
  initial begin
    ev_t e;
    int  c;
    int  op;
    int  r;
    logic [7:0] a;
    n_checks = 0;
    n_fail   = 0;
    last_wr  = 8'h00;
    rst  = 1'b1;
    wr_b = 1'b1;
    rd_b = 1'b1;
    addr = 8'h00;
    din  = 8'h00;
    repeat (3) @(negedge clk);
    chk_eq("reset_outputs",
           int'({wr_pulse_out, rd_pulse_out, port_sel_out, wr_data_out, z80_bus_dir, conflict_out}), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    bus_cycle(0, 8'h80, 8'hA5, 10, 4);   // data write
    bus_cycle(1, 8'h81, 8'h00, 8, 4);    // status read
    bus_cycle(0, 8'h10, 8'h77, 8, 4);    // non-matching write
    bus_cycle(1, 8'h10, 8'h00, 8, 4);    // non-matching read
    bus_cycle(1, 8'h80, 8'h00, 1, 4);    // glitch
    bus_cycle(1, 8'h80, 8'h00, 8, 4);
    bus_cycle(2, 8'h80, 8'h00, 6, 4);    // both strobes
    bus_cycle(0, 8'h80, 8'h3C, 8, 4);

    // reset in the middle of a read hold
    @(negedge clk);
    c    = cyc;
    addr = 8'h81;
    rd_b = 1'b0;
    e = '{kind: K_RD, sel: 1'b1, wdata: last_wr, t: 32'(c + LAT)};
    exp_q.push_back(e);
    repeat (9) @(negedge clk);
    chk_eq("dir_before_reset", int'(z80_bus_dir), 1);
    #2 rst = 1'b1;
    #1;
    chk_eq("reset_async_dir", int'(z80_bus_dir), 0);
    chk_eq("reset_async_outs",
           int'({wr_pulse_out, rd_pulse_out, port_sel_out, wr_data_out, conflict_out}), 0);
    @(negedge clk);
    rst     = 1'b0;
    last_wr = 8'h00;
    c       = cyc;
    e = '{kind: K_RD, sel: 1'b1, wdata: last_wr, t: 32'(c + LAT)};
    exp_q.push_back(e);
    dir_q.push_back(8'(8 - FILTER));
    repeat (8) @(negedge clk);
    rd_b = 1'b1;
    repeat (5) @(negedge clk);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 3);
      a = (r == 0) ? 8'h80 : (r == 1) ? 8'h81 : 8'($urandom_range(0, 255));
      op = $urandom_range(0, 9);
      if (op <= 3)
        bus_cycle(0, a, 8'($urandom_range(0, 255)), $urandom_range(4, 12), $urandom_range(3, 6));
      else if (op <= 7)
        bus_cycle(1, a, 8'($urandom_range(0, 255)), $urandom_range(4, 12), $urandom_range(3, 6));
      else if (op == 8)
        bus_cycle(2, a, 8'h00, $urandom_range(1, 8), $urandom_range(3, 6));
      else
        bus_cycle($urandom_range(0, 1), a, 8'($urandom_range(0, 255)), 1, $urandom_range(3, 6));
    end

    repeat (20) @(negedge clk);
    chk_eq("events_left", exp_q.size(), 0);
    chk_eq("dir_windows_left", dir_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
